oam_dma: RTL and testbench
==========================

# oam_dma

Sprite-attribute DMA engine that sits directly upstream of the PPU's CPU/OAM port. On a CPU start request it copies 64 consecutive 32-bit sprite words (`[X, Y, PatternIndex, PaletteIndex]`, byte 0 = X) from CPU memory into OAM. It drives the PPU's `cpu_oam_data`, `cpu_oam_addr` and `cpu_write` inputs. Reads and OAM writes happen only while `rendering` is low, so no PPU write is ever dropped.

## Interface
Parameters:
- `ADDR_W`, 16, CPU memory word-address width
- `NUM_OBJ`, 64, objects per transfer; fixed at 64 (6-bit OAM index)

Ports:
- `clk`  in  1  system clock, shared with the PPU
- `reset`  in  1  reset, asynchronous, active-low
- `start`  in  1  single-cycle request; honoured only in IDLE
- `src_base`  in  ADDR_W  first source word address; sampled with `start`
- `rendering`  in  1  PPU/VGA active-display flag; high = pause
- `mem_addr`  out  ADDR_W  CPU memory read address
- `mem_rd`  out  1  read strobe; data returns on `mem_rdata` one cycle later
- `mem_rdata`  in  32  read data
- `oam_data`  out  32  to PPU `cpu_oam_data`
- `oam_addr`  out  6  to PPU `cpu_oam_addr`
- `oam_write`  out  1  to PPU `cpu_write`
- `busy`  out  1  transfer in progress (READ/LATCH/WRITE/DONE)
- `done`  out  1  one-cycle completion pulse
- `irq`  out  1  sticky completion interrupt (see Configuration)
- `irq_ack`  in  1  clears `irq`

## Operation
- Registers:
  - `src_reg` (ADDR_W), captured from `src_base` on accepted `start`.
  - `idx` (6 bits), object counter.
  - `data_reg` (32), drives `oam_data`.
  - `addr_reg` (6), drives `oam_addr`.
- States: IDLE, READ, LATCH, WRITE, DONE.
  - **IDLE**:
    - On `start`: `src_reg <= src_base`, `idx <= 0`, go to READ.
    - Otherwise stay.
  - **READ**:
    - Outputs: `mem_addr = src_reg + idx`, truncated to ADDR_W (wraps modulo 2^ADDR_W); `mem_rd = ~rendering` (combinational).
    - If `rendering` is 1, stay in READ.
    - Otherwise go to LATCH.
  - **LATCH**: `data_reg <= mem_rdata`, `addr_reg <= idx`, go to WRITE. `rendering` is ignored here.
  - **WRITE**:
    - `oam_write = ~rendering` (combinational).
    - If `rendering` is 1, hold; `data_reg`/`addr_reg` are unchanged.
    - Otherwise the write completes at this edge:
      - If `idx == 63`, go to DONE.
      - Else `idx <= idx + 1` and go to READ.
  - **DONE**: `done = 1` for exactly this cycle, then go to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `busy = (state != IDLE)`.
- Reset mid-transfer aborts immediately. OAM keeps whatever words were already written; no rollback.

## Timing
- Reset values:
  - state IDLE.
  - `mem_addr`, `oam_data`, `oam_addr` = 0.
  - `mem_rd`, `oam_write`, `busy`, `done`, `irq` = 0.
- Unstalled transfer:
  - `start` sampled at edge E0; READ occupies cycle 1.
  - Object k:
    - READ in cycle 3k+1.
    - LATCH in cycle 3k+2.
    - WRITE in cycle 3k+3.
  - DONE in cycle 193.
  - `busy` high for 193 cycles.
- Each cycle spent in READ or WRITE with `rendering` high adds one cycle. LATCH is never stalled.
- `oam_write` and `rendering` are evaluated in the same cycle. The PPU therefore never sees a write it ignores.
- The PPU returns `oam_out` one cycle after `oam_addr` settles. This block does not read it.

## Configuration
- Macro: `OAM_DMA_IRQ_EN`.
- Defined:
  - `irq` is set on the DONE cycle and stays high until a cycle with `irq_ack = 1`.
  - If set and `irq_ack` coincide, set wins.
  - `irq_ack` while `irq` is low has no effect.
- Undefined:
  - `irq` is tied to 0 and `irq_ack` is ignored.
  - `done` and `busy` behave the same in both builds.

## Test plan
- `src_base=16'h0100`, memory word n = `{8'hn, 8'h0n, 8'h20, 8'h10+n}`-style pattern, `rendering=0`, one `start` pulse. Required:
  - 64 `oam_write` pulses, `oam_addr` 0..63 in order, data matching words 0x100..0x13F.
  - `done` on cycle 193.
  - `busy` low on cycle 194.
- `rendering` high for 10 cycles starting while in READ of object 5:
  - `mem_rd` is low throughout the stall.
  - Transfer resumes with the same `mem_addr` (0x105).
  - `done` arrives on cycle 203.
- `rendering` rises during WRITE of object 20:
  - `oam_write` is low while `rendering` is high.
  - `oam_addr`=20 and `oam_data` are held.
  - A single write of object 20 follows when `rendering` falls.
- `src_base=16'hFFF0`:
  - `mem_addr` sequence is FFF0..FFFF, then 0000..002F.
  - A second `start` at cycle 50 is ignored; exactly 64 writes occur.
- Assert `reset=0` at cycle 100 of a transfer:
  - All outputs go to 0 asynchronously.
  - After release, no `oam_write` occurs without a new `start`.
- With `OAM_DMA_IRQ_EN`:
  - `irq` rises with `done` and stays high.
  - `irq_ack` at cycle 300 clears it at the next edge.
  - Without the macro, `irq` stays 0 throughout.

Source files
------------

// File: rtl/oam_dma_if.sv
// Bus bundle between the OAM DMA engine and its surroundings: CPU control,
// CPU memory read port and the PPU CPU/OAM write port.
interface oam_dma_if #(
  parameter int ADDR_W = 16
);
  // CPU control
  logic              start;
  logic [ADDR_W-1:0] src_base;
  logic              busy;
  logic              done;
  logic              irq;
  logic              irq_ack;

  // PPU display status
  logic              rendering;

  // CPU memory read port (one-cycle read latency)
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_rdata;

  // PPU OAM write port
  logic [31:0]       oam_data;
  logic [5:0]        oam_addr;
  logic              oam_write;

  // The DMA engine masters both the memory read port and the OAM port.
  modport master (
    input  start, src_base, irq_ack, rendering, mem_rdata,
    output busy, done, irq, mem_addr, mem_rd, oam_data, oam_addr, oam_write
  );

  // Environment side: CPU, memory and PPU.
  modport slave (
    output start, src_base, irq_ack, rendering, mem_rdata,
    input  busy, done, irq, mem_addr, mem_rd, oam_data, oam_addr, oam_write
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite-attribute DMA: copies 64 words from CPU memory into PPU OAM, pausing
// while the PPU renders. Define OAM_DMA_IRQ_EN to build the sticky irq output.
module oam_dma #(
  parameter int ADDR_W  = 16,
  parameter int NUM_OBJ = 64
) (
  input  logic      clk,
  input  logic      reset,
  oam_dma_if.master bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [5:0] LAST_IDX = 6'(NUM_OBJ - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q,   src_d;
  logic [5:0]        idx_q,   idx_d;
  logic [31:0]       data_q,  data_d;
  logic [5:0]        addr_q,  addr_d;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    data_d  = data_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          src_d   = bus.src_base;
          idx_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (!bus.rendering) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        // Read data is valid exactly one cycle after the strobe.
        data_d  = bus.mem_rdata;
        addr_d  = idx_q;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (!bus.rendering) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  logic in_read, in_write, in_done;
  assign in_read  = (state_q == ST_READ);
  assign in_write = (state_q == ST_WRITE);
  assign in_done  = (state_q == ST_DONE);

  // Address wraps modulo 2^ADDR_W; outside READ the bus is parked at zero.
  assign bus.mem_addr  = in_read ? ADDR_W'(src_q + ADDR_W'(idx_q)) : '0;
  assign bus.mem_rd    = in_read & ~bus.rendering;
  assign bus.oam_data  = data_q;
  assign bus.oam_addr  = addr_q;
  // Gated by rendering in the same cycle so the PPU never drops a write.
  assign bus.oam_write = in_write & ~bus.rendering;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = in_done;

`ifdef OAM_DMA_IRQ_EN
  logic irq_q, irq_d;

  // Completion sets the flag (winning over a coincident ack); ack clears it.
  always_comb begin
    irq_d = irq_q;
    if (in_done)          irq_d = 1'b1;
    else if (bus.irq_ack) irq_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  // Visible from the DONE cycle itself, then held by the register.
  assign bus.irq = irq_q | in_done;
`else
  wire unused_irq_ack = &{1'b0, bus.irq_ack};
  assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: random memory contents and rendering
// windows checked against a cycle-level transfer model.
`timescale 1ns/1ps
module tb_oam_dma;

  localparam int MAXC = 512;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  oam_dma_if #(.ADDR_W(16)) bus ();

  oam_dma #(.ADDR_W(16), .NUM_OBJ(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // CPU memory: one-cycle read latency.
  logic [31:0] mem [0:65535];
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  // Per-cycle logs of one run (cycle 0 = cycle in which start is driven).
  logic        rend_log  [MAXC];
  logic        rd_log    [MAXC];
  logic [15:0] maddr_log [MAXC];
  logic        wr_log    [MAXC];
  logic [5:0]  oaddr_log [MAXC];
  logic [31:0] odata_log [MAXC];
  logic        busy_log  [MAXC];
  logic        done_log  [MAXC];
  logic        irq_log   [MAXC];

  logic [5:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_cyc  [$];
  logic [15:0] rd_addr [$];
  int          done_cyc;
  int          done_cnt;
  int          busy_cnt;

  // Reference model: expected cycle of each object's write and of DONE.
  int exp_wr_cyc [64];
  int exp_done;

  function automatic bit in_win(int t, int rf, int rl);
    return (t >= rf) && (t < rf + rl);
  endfunction

  task automatic model(input int rf, input int rl);
    int t = 1;
    for (int k = 0; k < 64; k++) begin
      while (in_win(t, rf, rl)) t++;   // read waits for display blanking
      t++;                             // read issued
      t++;                             // data captured
      while (in_win(t, rf, rl)) t++;   // write waits for display blanking
      exp_wr_cyc[k] = t;
      t++;
    end
    exp_done = t;
  endtask

  task automatic run(input logic [15:0] base, input int rf, input int rl,
                     input int s2, input int rst_c, input int ack_c, input int ncyc);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); rd_addr.delete();
    done_cyc = -1; done_cnt = 0; busy_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.src_base = base; bus.rendering = 1'b0; bus.irq_ack = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        bus.start = (c == s2);
        if (c == s2) bus.src_base = 16'($urandom);
        bus.rendering = in_win(c, rf, rl);
        bus.irq_ack = (c == ack_c);
        if (c == rst_c) reset = 1'b0;
        if (c == rst_c + 3) reset = 1'b1;
      end
      @(negedge clk);
      rend_log[c] = bus.rendering;  rd_log[c] = bus.mem_rd;
      maddr_log[c] = bus.mem_addr;  wr_log[c] = bus.oam_write;
      oaddr_log[c] = bus.oam_addr;  odata_log[c] = bus.oam_data;
      busy_log[c] = bus.busy;       done_log[c] = bus.done;
      irq_log[c] = bus.irq;
      if (bus.oam_write) begin
        wr_addr.push_back(bus.oam_addr); wr_data.push_back(bus.oam_data); wr_cyc.push_back(c);
      end
      if (bus.mem_rd) rd_addr.push_back(bus.mem_addr);
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.busy) busy_cnt++;
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rendering = 1'b0; bus.irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    reset = 1'b0;
    bus.start = 1'b0; bus.src_base = '0; bus.rendering = 1'b0; bus.irq_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {bus.mem_addr, 6'(bus.oam_addr), bus.mem_rd, bus.oam_write, bus.busy, bus.done, bus.irq, 3'b0};
    vectors++;
    if (got !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %h required 0", got);
    end
    vectors++;
    if (bus.oam_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0", bus.oam_data);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.oam_write !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy %b write %b required 0 0", bus.busy, bus.oam_write);
    end
  endtask

  task automatic test_basic();
    run(16'h0100, MAXC, 0, -1, -1, -1, 200);
    vectors++;
    if (wr_addr.size() != 64) begin
      miscompares++;
      $display("FAIL basic_wr_count: got %0d required 64", wr_addr.size());
    end
    for (int k = 0; k < 64 && k < wr_addr.size(); k++) begin
      vectors++;
      if (wr_addr[k] !== 6'(k) || wr_data[k] !== mem[16'h0100 + 16'(k)]) begin
        miscompares++;
        $display("FAIL basic_wr[%0d]: got %0d/%h required %0d/%h", k, wr_addr[k], wr_data[k], k, mem[16'h0100 + 16'(k)]);
      end
      vectors++;
      if (wr_cyc[k] != 3 * k + 3) begin
        miscompares++;
        $display("FAIL basic_wr_cyc[%0d]: got %0d required %0d", k, wr_cyc[k], 3 * k + 3);
      end
    end
    vectors++;
    if (done_cyc != 193 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL basic_done: cycle %0d count %0d required 193 1", done_cyc, done_cnt);
    end
    vectors++;
    if (busy_cnt != 193 || busy_log[193] !== 1'b1 || busy_log[194] !== 1'b0 || busy_log[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy: count %0d b193 %b b194 %b required 193 1 0", busy_cnt, busy_log[193], busy_log[194]);
    end
  endtask

  task automatic test_read_stall();
    int first_rd;
    int bad;
    run(16'h0100, 16, 10, -1, -1, -1, 215);
    model(16, 10);
    bad = 0;
    for (int c = 16; c < 26; c++) if (rd_log[c] !== 1'b0) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rstall_mem_rd: %0d cycles with mem_rd high required 0", bad);
    end
    first_rd = -1;
    for (int c = 16; c < 40 && first_rd < 0; c++) if (rd_log[c] === 1'b1) first_rd = c;
    vectors++;
    if (first_rd != 26 || maddr_log[26] !== 16'h0105) begin
      miscompares++;
      $display("FAIL rstall_resume: cycle %0d addr %h required 26 0105", first_rd, maddr_log[26]);
    end
    vectors++;
    if (done_cyc != exp_done || done_cyc != 203) begin
      miscompares++;
      $display("FAIL rstall_done: got %0d required 203", done_cyc);
    end
    vectors++;
    if (wr_addr.size() != 64) begin
      miscompares++;
      $display("FAIL rstall_wr_count: got %0d required 64", wr_addr.size());
    end
  endtask

  task automatic test_write_stall();
    logic [15:0] base;
    int n20;
    base = 16'($urandom);
    run(base, 63, 4, -1, -1, -1, 210);
    model(63, 4);
    for (int c = 63; c < 67; c++) begin
      vectors++;
      if (wr_log[c] !== 1'b0 || oaddr_log[c] !== 6'd20 || odata_log[c] !== mem[base + 16'd20]) begin
        miscompares++;
        $display("FAIL wstall_hold[%0d]: wr %b addr %0d data %h required 0 20 %h", c, wr_log[c], oaddr_log[c], odata_log[c], mem[base + 16'd20]);
      end
    end
    n20 = 0;
    foreach (wr_addr[i]) if (wr_addr[i] == 6'd20) n20++;
    vectors++;
    if (n20 != 1 || wr_log[67] !== 1'b1) begin
      miscompares++;
      $display("FAIL wstall_single: %0d writes of obj 20, wr at 67 %b required 1 1", n20, wr_log[67]);
    end
    for (int k = 0; k < 64 && k < wr_addr.size(); k++) begin
      vectors++;
      if (wr_addr[k] !== 6'(k) || wr_data[k] !== mem[base + 16'(k)] || wr_cyc[k] != exp_wr_cyc[k]) begin
        miscompares++;
        $display("FAIL wstall_wr[%0d]: got %0d/%h@%0d required %0d/%h@%0d", k, wr_addr[k], wr_data[k], wr_cyc[k], k, mem[base + 16'(k)], exp_wr_cyc[k]);
      end
    end
    vectors++;
    if (done_cyc != exp_done) begin
      miscompares++;
      $display("FAIL wstall_done: got %0d required %0d", done_cyc, exp_done);
    end
  endtask

  task automatic test_wrap();
    run(16'hFFF0, MAXC, 0, 50, -1, -1, 210);
    vectors++;
    if (rd_addr.size() != 64 || wr_addr.size() != 64) begin
      miscompares++;
      $display("FAIL wrap_counts: reads %0d writes %0d required 64 64", rd_addr.size(), wr_addr.size());
    end
    for (int k = 0; k < 64 && k < rd_addr.size() && k < wr_addr.size(); k++) begin
      vectors++;
      if (rd_addr[k] !== 16'(32'hFFF0 + k) || wr_data[k] !== mem[16'(32'hFFF0 + k)]) begin
        miscompares++;
        $display("FAIL wrap[%0d]: addr %h data %h required %h %h", k, rd_addr[k], wr_data[k], 16'(32'hFFF0 + k), mem[16'(32'hFFF0 + k)]);
      end
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL wrap_done_count: got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_abort();
    int late;
    run(16'($urandom), MAXC, 0, -1, 100, -1, 300);
    vectors++;
    if ({maddr_log[100], rd_log[100], wr_log[100], busy_log[100], done_log[100], irq_log[100]} !== 21'h0
        || oaddr_log[100] !== 6'd0 || odata_log[100] !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_async: addr %h rd %b wr %b busy %b oaddr %0d odata %h required all 0",
               maddr_log[100], rd_log[100], wr_log[100], busy_log[100], oaddr_log[100], odata_log[100]);
    end
    late = 0;
    for (int i = 0; i < wr_cyc.size(); i++) if (wr_cyc[i] >= 100) late++;
    vectors++;
    if (late != 0 || done_cnt != 0 || busy_log[299] !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_quiet: late writes %0d dones %0d busy %b required 0 0 0", late, done_cnt, busy_log[299]);
    end
  endtask

  task automatic test_irq();
    int bad;
    run(16'($urandom), MAXC, 0, -1, -1, 300, 305);
    bad = 0;
`ifdef OAM_DMA_IRQ_EN
    for (int c = 0; c < 305; c++) if (irq_log[c] !== ((c >= 193 && c <= 300) ? 1'b1 : 1'b0)) bad++;
`else
    for (int c = 0; c < 305; c++) if (irq_log[c] !== 1'b0) bad++;
`endif
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL irq_profile: %0d cycles wrong, irq@193 %b irq@301 %b", bad, irq_log[193], irq_log[301]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [15:0] base;
      int rf, rl, bad;
      base = 16'($urandom);
      rf = int'($urandom_range(1, 190));
      rl = int'($urandom_range(1, 20));
      run(base, rf, rl, -1, -1, -1, 225);
      model(rf, rl);
      bad = 0;
      if (wr_addr.size() != 64) bad++;
      for (int k = 0; k < 64 && k < wr_addr.size(); k++)
        if (wr_addr[k] !== 6'(k) || wr_data[k] !== mem[base + 16'(k)] || wr_cyc[k] != exp_wr_cyc[k]) bad++;
      for (int c = 0; c < 225; c++) if (rend_log[c] && (rd_log[c] || wr_log[c])) bad++;
      vectors++;
      if (bad != 0 || done_cyc != exp_done) begin
        miscompares++;
        $display("FAIL random[%0d] base %h win %0d+%0d: %0d bad, done %0d required %0d", it, base, rf, rl, bad, done_cyc, exp_done);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    for (int n = 0; n < 64; n++) mem[16'h0100 + n] = {8'(n), 8'(n), 8'h20, 8'h10 + 8'(n)};
    test_reset();
    test_basic();
    test_read_stall();
    test_write_stall();
    test_wrap();
    test_abort();
    test_irq();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
